// File: rtl/qoi_pkg.sv
// Shared QOI channel package: byte size constant and the 0-means-full byte count decoder.
package qoi_pkg;

    localparam int unsigned QOI_BYTE = 32'd8;

    // Decode a byte count where 0 stands for a full bus of 'width' bits.
    function automatic int unsigned qoi_nbytes(input int unsigned bytes, input int unsigned width);
        int unsigned n_s;
        if (bytes == 32'd0) begin
            n_s = width / QOI_BYTE;
        end else begin
            n_s = bytes;
        end
        return n_s;
    endfunction

endpackage

// File: rtl/qoi_regauge.sv
// Byte-stream width converter: repacks IDW-bit partial beats into dense ODW-bit beats.
// Optional macro QOI_REGAUGE_COUNT_EN adds o_frame_bytes (byte total of the last completed frame).
module qoi_regauge
    import qoi_pkg::*;
#(
    parameter int unsigned IDW = 64,
    parameter int unsigned ODW = 32
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [IDW-1:0]            s_data,
    input  logic [$clog2(IDW/8)-1:0]  s_bytes,
    input  logic                      s_last,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [ODW-1:0]            m_data,
    output logic [$clog2(ODW/8)-1:0]  m_bytes,
    output logic                      m_last
`ifdef QOI_REGAUGE_COUNT_EN
    ,
    output logic [31:0]               o_frame_bytes
`endif
);

    localparam int unsigned IB  = IDW / QOI_BYTE;
    localparam int unsigned OB  = ODW / QOI_BYTE;
    localparam int unsigned B   = IB + OB;
    localparam int unsigned BW  = B * QOI_BYTE;
    localparam int unsigned FW  = $clog2(B + 1);
    localparam int unsigned MBW = $clog2(OB);

    // Buffer byte 0 sits in the MSBs; bytes at or beyond fill are kept zero.
    logic [BW-1:0]  buf_q, buf_d, shf_buf_s, ext_s;
    logic [FW-1:0]  fill_q, fill_d, shf_fill_s, n_s, popped_s;
    logic           lastp_q, lastp_d, shf_lastp_s;
    logic           m_valid_q, m_valid_d, m_last_q, m_last_d;
    logic [ODW-1:0] m_data_q, m_data_d;
    logic [MBW-1:0] m_bytes_q, m_bytes_d;
    logic [IDW-1:0] mask_s;
    logic           accept_s, pop_s;

    assign s_ready  = !lastp_q && (fill_q <= FW'(OB));
    assign accept_s = s_valid && s_ready;
    assign pop_s    = m_valid_q && m_ready;

    // Pop first, then append accepted bytes at the post-pop fill offset.
    always_comb begin
        n_s      = FW'(qoi_nbytes(32'(s_bytes), IDW));
        mask_s   = ~({IDW{1'b1}} >> (32'(n_s) * QOI_BYTE));
        ext_s    = {s_data & mask_s, {ODW{1'b0}}};
        popped_s = (fill_q >= FW'(OB)) ? FW'(OB) : fill_q;
        if (pop_s) begin
            shf_buf_s = buf_q << ODW;
            if (m_last_q) begin
                shf_fill_s  = FW'(0);
                shf_lastp_s = 1'b0;
            end else begin
                shf_fill_s  = fill_q - popped_s;
                shf_lastp_s = lastp_q;
            end
        end else begin
            shf_buf_s   = buf_q;
            shf_fill_s  = fill_q;
            shf_lastp_s = lastp_q;
        end
        if (accept_s) begin
            buf_d   = shf_buf_s | (ext_s >> (32'(shf_fill_s) * QOI_BYTE));
            fill_d  = shf_fill_s + n_s;
            lastp_d = s_last;
        end else begin
            buf_d   = shf_buf_s;
            fill_d  = shf_fill_s;
            lastp_d = shf_lastp_s;
        end
        m_valid_d = (fill_d >= FW'(OB)) || (lastp_d && (fill_d != FW'(0)));
        m_data_d  = buf_d[BW-1 -: ODW];
        m_bytes_d = (fill_d >= FW'(OB)) ? MBW'(0) : MBW'(fill_d);
        m_last_d  = lastp_d && (fill_d <= FW'(OB));
    end

    // Buffer state and registered output beat.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            buf_q     <= {BW{1'b0}};
            fill_q    <= FW'(0);
            lastp_q   <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= {ODW{1'b0}};
            m_bytes_q <= MBW'(0);
            m_last_q  <= 1'b0;
        end else begin
            buf_q     <= buf_d;
            fill_q    <= fill_d;
            lastp_q   <= lastp_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_bytes_q <= m_bytes_d;
            m_last_q  <= m_last_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_bytes = m_bytes_q;
    assign m_last  = m_last_q;

`ifdef QOI_REGAUGE_COUNT_EN
    logic [31:0] run_cnt_q, run_cnt_d, frame_bytes_q, frame_bytes_d;

    // Running byte count latched into the frame total when the last beat pops.
    always_comb begin
        if (pop_s && m_last_q) begin
            run_cnt_d     = 32'd0;
            frame_bytes_d = run_cnt_q;
        end else if (accept_s) begin
            run_cnt_d     = run_cnt_q + 32'(n_s);
            frame_bytes_d = frame_bytes_q;
        end else begin
            run_cnt_d     = run_cnt_q;
            frame_bytes_d = frame_bytes_q;
        end
    end

    // Frame byte counter registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            run_cnt_q     <= 32'd0;
            frame_bytes_q <= 32'd0;
        end else begin
            run_cnt_q     <= run_cnt_d;
            frame_bytes_q <= frame_bytes_d;
        end
    end

    assign o_frame_bytes = frame_bytes_q;
`endif

endmodule

// File: tb/tb_qoi_regauge.sv
// Self-checking bench for qoi_regauge: byte-queue reference model plus directed literal checks.
module tb_qoi_regauge;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        s_valid = 1'b0, s_last = 1'b0;
    logic [63:0] s_data = 64'd0;
    logic [2:0]  s_bytes = 3'd0;
    logic        s_ready, m_valid, m_last, m_ready;
    logic [31:0] m_data;
    logic [1:0]  m_bytes;
    logic        mr_fixed = 1'b1, rnd_mode = 1'b0, rnd_bit = 1'b0;
    assign m_ready = rnd_mode ? rnd_bit : mr_fixed;
`ifdef QOI_REGAUGE_COUNT_EN
    logic [31:0] frame_bytes, w_frame_bytes;
`endif

    logic        w_s_valid = 1'b0;
    logic [31:0] w_s_data = 32'd0;
    logic [1:0]  w_s_bytes = 2'd0;
    logic        w_s_last = 1'b0, w_m_ready = 1'b1;
    logic        w_s_ready, w_m_valid, w_m_last;
    logic [63:0] w_m_data;
    logic [2:0]  w_m_bytes;

    qoi_regauge #(.IDW(64), .ODW(32)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_bytes(s_bytes), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_bytes(m_bytes), .m_last(m_last)
`ifdef QOI_REGAUGE_COUNT_EN
        , .o_frame_bytes(frame_bytes)
`endif
    );

    qoi_regauge #(.IDW(32), .ODW(64)) dut_w (
        .i_clk(clk), .i_reset_n(rst_n),
        .s_valid(w_s_valid), .s_ready(w_s_ready), .s_data(w_s_data), .s_bytes(w_s_bytes), .s_last(w_s_last),
        .m_valid(w_m_valid), .m_ready(w_m_ready), .m_data(w_m_data), .m_bytes(w_m_bytes), .m_last(w_m_last)
`ifdef QOI_REGAUGE_COUNT_EN
        , .o_frame_bytes(w_frame_bytes)
`endif
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out", name);
    endtask

    // Reference model: pending frame bytes in arrival order, and whether the frame's last beat arrived.
    logic [7:0]  q[$];
    bit          done = 1'b0;
    int          fcnt = 0;
    int          exp_fb = 0;
    logic [31:0] log_d[$];
    logic [1:0]  log_b[$];
    logic        log_l[$];
    logic [63:0] wlog[$];

    always @(posedge clk) begin
        #1 rnd_bit = 1'($urandom_range(0, 1));
    end

    always @(negedge clk) begin
        logic [31:0] ed;
        logic        el;
        int          k;
        int          n;
        if (!rst_n) begin
            q.delete();
            done = 1'b0;
            fcnt = 0;
            exp_fb = 0;
        end else begin
`ifdef QOI_REGAUGE_COUNT_EN
            check("frame_bytes", 64'(frame_bytes), 64'(exp_fb));
`endif
            check("m_valid", 64'(m_valid), 64'((q.size() >= 4) || (done && q.size() > 0)));
            check("s_ready", 64'(s_ready), 64'(!done && q.size() <= 4));
            if (m_valid) begin
                k = (q.size() >= 4) ? 4 : q.size();
                ed = 32'd0;
                for (int i = 0; i < k; i++) ed[31-8*i -: 8] = q[i];
                el = done && (q.size() <= 4);
                check("m_data", 64'(m_data), 64'(ed));
                check("m_bytes", 64'(m_bytes), 64'((k == 4) ? 0 : k));
                check("m_last", 64'(m_last), 64'(el));
                if (m_ready) begin
                    log_d.push_back(m_data);
                    log_b.push_back(m_bytes);
                    log_l.push_back(m_last);
                    for (int i = 0; i < k; i++) void'(q.pop_front());
                    if (el) begin
                        done = 1'b0;
                        exp_fb = fcnt;
                        fcnt = 0;
                    end
                end
            end
            if (s_valid && s_ready) begin
                n = (s_bytes == 3'd0) ? 8 : int'(s_bytes);
                for (int i = 0; i < n; i++) q.push_back(s_data[63-8*i -: 8]);
                fcnt += n;
                if (s_last) done = 1'b1;
            end
        end
    end

    // Wide instance monitor: m_ready is tied high so every valid cycle is a pop.
    always @(negedge clk) begin
        if (rst_n && w_m_valid) begin
            wlog.push_back(w_m_data);
            check("w_m_bytes", 64'(w_m_bytes), 64'd0);
            check("w_m_last", 64'(w_m_last), 64'd0);
        end
    end

    task automatic send(input logic [63:0] d, input int n, input bit last);
        int budget;
        s_valid = 1'b1;
        s_data  = d;
        s_bytes = 3'(n % 8);
        s_last  = last;
        budget  = 0;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            budget++;
            if (budget > 200) begin
                timeout_fail("send");
                break;
            end
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        forever begin
            @(negedge clk);
            if (!m_valid && q.size() == 0 && !done) break;
            budget++;
            if (budget > 400) begin
                timeout_fail("drain");
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_d.delete();
        log_b.delete();
        log_l.delete();
    endtask

    task automatic chk_log(input int idx, input logic [31:0] d, input logic [1:0] b, input logic l);
        if (idx < log_d.size()) begin
            check($sformatf("beat%0d_data", idx), 64'(log_d[idx]), 64'(d));
            check($sformatf("beat%0d_bytes", idx), 64'(log_b[idx]), 64'(b));
            check($sformatf("beat%0d_last", idx), 64'(log_l[idx]), 64'(l));
        end else begin
            timeout_fail($sformatf("beat%0d_missing", idx));
        end
    endtask

    initial begin
        logic [31:0] wd[4];
        int          len;
        int          n;
        wd[0] = 32'h01020304; wd[1] = 32'h05060708; wd[2] = 32'h090A0B0C; wd[3] = 32'h0D0E0F10;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_data", 64'(m_data), 64'd0);
        check("rst_m_bytes", 64'(m_bytes), 64'd0);
        check("rst_m_last", 64'(m_last), 64'd0);
        check("rst_s_ready", 64'(s_ready), 64'd1);

        // One full 8-byte beat with last splits into two full 4-byte beats.
        clear_log();
        send(64'h0011223344556677, 8, 1'b1);
        drain();
        check("t1_count", 64'(log_d.size()), 64'd2);
        chk_log(0, 32'h00112233, 2'd0, 1'b0);
        chk_log(1, 32'h44556677, 2'd0, 1'b1);

        // 3 + 3 + 1 bytes; garbage in unused input bytes must not leak.
        clear_log();
        send(64'hAABBCCFFFFFFFFFF, 3, 1'b0);
        send(64'hDDEEFF0123456789, 3, 1'b0);
        send(64'h11FFFFFFFFFFFFFF, 1, 1'b1);
        drain();
        check("t2_count", 64'(log_d.size()), 64'd2);
        chk_log(0, 32'hAABBCCDD, 2'd0, 1'b0);
        chk_log(1, 32'hEEFF1100, 2'd3, 1'b1);

        // 32-bit in, 64-bit out: four full beats back to back, s_ready stays high.
        w_s_valid = 1'b1;
        w_s_bytes = 2'd0;
        for (int i = 0; i < 4; i++) begin
            w_s_data = wd[i];
            @(negedge clk);
            check("w_s_ready", 64'(w_s_ready), 64'd1);
            @(posedge clk);
            #1;
        end
        w_s_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("w_count", 64'(wlog.size()), 64'd2);
        if (wlog.size() >= 2) begin
            check("w_beat0", wlog[0], 64'h0102030405060708);
            check("w_beat1", wlog[1], 64'h090A0B0C0D0E0F10);
        end

        // Random frames with random backpressure, checked cycle by cycle against the model.
        rnd_mode = 1'b1;
        for (int f = 0; f < 1000; f++) begin
            len = $urandom_range(1, 20);
            while (len > 0) begin
                n = $urandom_range(1, (len < 8) ? len : 8);
                send({$urandom, $urandom}, n, len == n);
                len -= n;
            end
        end
        drain();
        rnd_mode = 1'b0;

        // Reset mid-frame with 5 bytes buffered, then a fresh frame packs from byte 0.
        mr_fixed = 1'b0;
        send(64'h0102030405FFFFFF, 5, 1'b0);
        @(negedge clk);
        check("pre_rst_m_valid", 64'(m_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_m_valid", 64'(m_valid), 64'd0);
        check("mid_rst_m_data", 64'(m_data), 64'd0);
        check("mid_rst_m_last", 64'(m_last), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mr_fixed = 1'b1;
        clear_log();
        send(64'hA0A1A2A3A4A5A6A7, 8, 1'b1);
        drain();
        check("t5_count", 64'(log_d.size()), 64'd2);
        chk_log(0, 32'hA0A1A2A3, 2'd0, 1'b0);
        chk_log(1, 32'hA4A5A6A7, 2'd0, 1'b1);

        // 13-byte frame: 8 + 5 bytes.
        clear_log();
        send(64'h1011121314151617, 8, 1'b0);
        send(64'h18191A1B1CFFFFFF, 5, 1'b1);
        drain();
        check("t6_count", 64'(log_d.size()), 64'd4);
        chk_log(3, 32'h1C000000, 2'd1, 1'b1);
`ifdef QOI_REGAUGE_COUNT_EN
        check("frame_bytes_13", 64'(frame_bytes), 64'd13);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/qoi_regauge.md
# qoi_regauge

Parametrised byte-stream width converter for the QOI compressed channel. It accepts encoder-side beats of IDW bits carrying 1..IDW/8 valid bytes and repacks them into dense ODW-bit beats for the decoder, storage, or a DMA. It supports full AXI-style backpressure on both sides and flushes a partial word on frame end. It sits between `qoi_encoder` and any consumer whose bus width differs from the encoder's.

## Interface
- `IDW`, default 64: input data width in bits; power of two, ≥16.
- `ODW`, default 32: output data width in bits; power of two, ≥16.
- `i_clk`  in  1  clock; all logic on the rising edge.
- `i_reset_n`  in  1  asynchronous, active-low reset.
- `s_valid`  in  1  input beat valid.
- `s_ready`  out  1  input beat accepted when high with `s_valid`.
- `s_data`  in  IDW  input bytes, first byte in bits [IDW-1:IDW-8], MSB-first.
- `s_bytes`  in  $clog2(IDW/8)  valid byte count; 0 means all IDW/8 bytes.
- `s_last`  in  1  final beat of the compressed frame.
- `m_valid`  out  1  output beat valid.
- `m_ready`  in  1  output beat consumed.
- `m_data`  out  ODW  packed bytes, MSB-first; unused low bytes are zero.
- `m_bytes`  out  $clog2(ODW/8)  valid byte count; 0 means full.
- `m_last`  out  1  final beat of the frame.

## Operation
- Byte buffer of B = IDW/8 + ODW/8 bytes, plus fill counter `fill` (0..B) and flag `lastp`.
- Accept: `s_ready = !lastp && fill <= ODW/8`. On accept, the valid bytes are appended after the existing `fill` bytes. `fill += n`, where n is the decoded `s_bytes`. `lastp` is set if `s_last`.
- Emit: `m_valid` is high when `fill >= ODW/8`, or when `lastp && fill > 0`.
  - `m_data` holds the first ODW/8 buffer bytes.
  - `m_last = lastp && fill <= ODW/8`.
  - `m_bytes = (fill >= ODW/8) ? 0 : fill`.
- Pop on `m_valid && m_ready`: shift the buffer left by ODW/8 bytes and set `fill -= min(fill, ODW/8)`. Popping the `m_last` beat clears `lastp` and `fill`.
- Simultaneous accept and pop in the same cycle: new bytes land at offset `fill - popped`. Bytes are never dropped and never duplicated.
- A zero-byte frame cannot occur; every input beat carries ≥1 byte.
- Stability: while `m_valid && !m_ready`, `m_data`, `m_bytes`, and `m_last` hold.
- Reset (async, any time): `fill=0`, `lastp=0`, `m_valid=0`, `m_data=0`, `m_bytes=0`, `m_last=0`, `s_ready=1` once reset is released. A frame interrupted by reset is discarded.

## Timing
- All outputs are registered, except `s_ready`, which is combinational from registered `fill`/`lastp`.
- Latency: a beat accepted at cycle t with `fill=0` and n ≥ ODW/8 gives `m_valid` at t+1.
- Throughput: one output beat per cycle whenever enough bytes are buffered.
  - IDW == ODW with full beats sustains 1 beat/cycle both sides.
  - IDW > ODW stalls the input (IDW/ODW)-1 of every IDW/ODW cycles.
- Frame boundary: after `s_last` is accepted, input stalls until the `m_last` beat pops. The next frame may be accepted in that same pop cycle's successor (t+1).

## Configuration
- `QOI_REGAUGE_COUNT_EN` defined: adds output `o_frame_bytes` (32 bits).
  - Reset value 0.
  - Holds the total bytes of the last completed frame, updated in the cycle after its `m_last` pop.
  - An internal running counter clears at that pop.
- Undefined: no port, no counter logic.

## Structure
- Shared package `qoi_pkg`:
  - function `qoi_nbytes(bytes, width)`, which decodes a 0-means-full count;
  - constant `QOI_BYTE = 8`.
- No sub-module; single flat module `qoi_regauge`.

## Test plan
- IDW=64, ODW=32, one full beat `0x0011223344556677` with `s_last` → two beats: `0x00112233` (`m_bytes=0`), then `0x44556677` (`m_bytes=0`, `m_last=1`).
- IDW=64, ODW=32, beats of 3, 3, 1 bytes (`0xAABBCC…`, `0xDDEEFF…`, `0x11…`, last) → `0xAABBCCDD`, then `0xEEFF1100` with `m_bytes=3` and `m_last=1`.
- IDW=32, ODW=64, four full beats with no last → two 64-bit beats. `s_ready` never drops with `m_ready=1`.
- Random `m_ready` (50%) over 1000 random frames → output byte stream equals input byte stream; `m_data` is stable while stalled.
- Assert `i_reset_n=0` mid-frame with `fill=5` → `m_valid=0` and `fill=0` immediately; the next frame is packed from byte 0.
- With `QOI_REGAUGE_COUNT_EN`: a frame of 13 bytes → `o_frame_bytes=13` one cycle after the `m_last` pop.
